alarm_ctrl: RTL

//  Mode/alarm sequencer for the alarm-clock design. Turns debounced button pulses into time-set and

---
 rtl/alarm_ctrl_if.sv | 36 +++
 rtl/alarm_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl_if.sv
// Button, time and status bundle between the alarm sequencer and its surroundings.
// The master side drives buttons/ticks/running time; the slave side is alarm_ctrl.
interface alarm_ctrl_if;
    logic       sec_tick;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_ok;
    logic       btn_snooze;
    logic [3:0] hourdec_now;
    logic [3:0] hourone_now;
    logic [3:0] mindec_now;
    logic [3:0] minone_now;
    logic [3:0] hourdec_init;
    logic [3:0] hourone_init;
    logic [3:0] mindec_init;
    logic [3:0] minone_init;
    logic       time_load;
    logic       alm_en;
    logic       ringing;
    logic [2:0] mode;
    logic       disp_sel;

    modport master (
        output sec_tick, btn_mode, btn_inc, btn_ok, btn_snooze,
        output hourdec_now, hourone_now, mindec_now, minone_now,
        input  hourdec_init, hourone_init, mindec_init, minone_init,
        input  time_load, alm_en, ringing, mode, disp_sel
    );

    modport slave (
        input  sec_tick, btn_mode, btn_inc, btn_ok, btn_snooze,
        input  hourdec_now, hourone_now, mindec_now, minone_now,
        output hourdec_init, hourone_init, mindec_init, minone_init,
        output time_load, alm_en, ringing, mode, disp_sel
    );
endinterface

// File: rtl/alarm_ctrl.sv
// Mode/alarm sequencer: time and alarm editing, time load strobe, alarm match,
// ring / snooze / auto-off timing. All outputs come straight from registers.
module alarm_ctrl #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300
) (
    input  logic         clk,
    input  logic         rstn,
    alarm_ctrl_if.slave  bus
);
    localparam int RW = (RING_SEC   > 1) ? $clog2(RING_SEC)   : 1;
    localparam int SW = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;
    localparam logic [RW-1:0] RING_LAST   = RW'(RING_SEC - 1);
    localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SEC - 1);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_H  = 3'd1,
        SET_M  = 3'd2,
        ALM_H  = 3'd3,
        ALM_M  = 3'd4,
        RING   = 3'd5,
        SNOOZE = 3'd6
    } state_t;

    state_t        state_r;
    logic [15:0]   edit_r;
    logic [15:0]   alarm_r;
    logic          alm_en_r;
    logic          ringing_r;
    logic          time_load_r;
    logic          disp_sel_r;
    logic          match_armed_r;
    logic [RW-1:0] ring_cnt_r;
    logic [SW-1:0] snz_cnt_r;

    logic [15:0]   now_s;
    logic          match_s;
    logic          ok_s;
    logic          snooze_s;
    logic          mode_s;
    logic          inc_s;

    // BCD hours 00..23 in the upper byte of an hh:mm word, minutes untouched
    function automatic logic [15:0] inc_hours(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if ((t[15:12] == 4'd2) && (t[11:8] == 4'd3)) begin
            r[15:8] = 8'h00;
        end else if (t[11:8] == 4'd9) begin
            r[15:12] = t[15:12] + 4'd1;
            r[11:8]  = 4'd0;
        end else begin
            r[11:8]  = t[11:8] + 4'd1;
        end
        return r;
    endfunction

    // BCD minutes 00..59 in the lower byte, hours untouched
    function automatic logic [15:0] inc_mins(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if ((t[7:4] == 4'd5) && (t[3:0] == 4'd9)) begin
            r[7:0] = 8'h00;
        end else if (t[3:0] == 4'd9) begin
            r[7:4] = t[7:4] + 4'd1;
            r[3:0] = 4'd0;
        end else begin
            r[3:0] = t[3:0] + 4'd1;
        end
        return r;
    endfunction

    // Simultaneous buttons resolve ok > snooze > mode > inc; losers are dropped
    always_comb begin
        now_s    = {bus.hourdec_now, bus.hourone_now, bus.mindec_now, bus.minone_now};
        match_s  = (now_s == alarm_r);
        ok_s     = bus.btn_ok;
        snooze_s = bus.btn_snooze & ~bus.btn_ok;
        mode_s   = bus.btn_mode & ~bus.btn_snooze & ~bus.btn_ok;
        inc_s    = bus.btn_inc & ~bus.btn_mode & ~bus.btn_snooze & ~bus.btn_ok;
    end

    // Sequencer state, edit/alarm registers, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r       <= RUN;
            edit_r        <= 16'h0000;
            alarm_r       <= 16'h0000;
            alm_en_r      <= 1'b0;
            ringing_r     <= 1'b0;
            time_load_r   <= 1'b0;
            disp_sel_r    <= 1'b0;
            match_armed_r <= 1'b0;
            ring_cnt_r    <= '0;
            snz_cnt_r     <= '0;
        end else begin
            time_load_r <= 1'b0;
            // Armed only after a non-matching cycle, so each match minute rings once
            match_armed_r <= ~match_s;
            case (state_r)
                RUN: begin
                    if (alm_en_r && match_s && match_armed_r) begin
                        state_r    <= RING;
                        ringing_r  <= 1'b1;
                        ring_cnt_r <= '0;
                    end else if (ok_s) begin
                        alm_en_r <= ~alm_en_r;
                    end else if (mode_s) begin
                        state_r    <= SET_H;
                        disp_sel_r <= 1'b1;
                        edit_r     <= now_s;
                    end
                end
                SET_H, SET_M: begin
                    if (ok_s) begin
                        time_load_r <= 1'b1;
                        state_r     <= RUN;
                        disp_sel_r  <= 1'b0;
                    end else if (mode_s && (state_r == SET_H)) begin
                        state_r <= SET_M;
                    end else if (mode_s) begin
                        state_r <= ALM_H;
                        edit_r  <= alarm_r;
                    end else if (inc_s && (state_r == SET_H)) begin
                        edit_r <= inc_hours(edit_r);
                    end else if (inc_s) begin
                        edit_r <= inc_mins(edit_r);
                    end
                end
                ALM_H, ALM_M: begin
                    if (ok_s) begin
                        alarm_r    <= edit_r;
                        state_r    <= RUN;
                        disp_sel_r <= 1'b0;
                    end else if (mode_s && (state_r == ALM_H)) begin
                        state_r <= ALM_M;
                    end else if (mode_s) begin
                        state_r    <= RUN;
                        disp_sel_r <= 1'b0;
                    end else if (inc_s && (state_r == ALM_H)) begin
                        edit_r <= inc_hours(edit_r);
                    end else if (inc_s) begin
                        edit_r <= inc_mins(edit_r);
                    end
                end
                RING: begin
                    if (ok_s) begin
                        state_r   <= RUN;
                        ringing_r <= 1'b0;
                    end else if (snooze_s) begin
                        state_r   <= SNOOZE;
                        ringing_r <= 1'b0;
                        snz_cnt_r <= '0;
                    end else if (bus.sec_tick && (ring_cnt_r == RING_LAST)) begin
                        state_r   <= RUN;
                        ringing_r <= 1'b0;
                    end else if (bus.sec_tick) begin
                        ring_cnt_r <= ring_cnt_r + 1'b1;
                    end
                end
                SNOOZE: begin
                    if (ok_s) begin
                        state_r <= RUN;
                    end else if (bus.sec_tick && (snz_cnt_r == SNOOZE_LAST)) begin
                        state_r    <= RING;
                        ringing_r  <= 1'b1;
                        ring_cnt_r <= '0;
                    end else if (bus.sec_tick) begin
                        snz_cnt_r <= snz_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r    <= RUN;
                    ringing_r  <= 1'b0;
                    disp_sel_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hourdec_init = edit_r[15:12];
    assign bus.hourone_init = edit_r[11:8];
    assign bus.mindec_init  = edit_r[7:4];
    assign bus.minone_init  = edit_r[3:0];
    assign bus.time_load    = time_load_r;
    assign bus.alm_en       = alm_en_r;
    assign bus.ringing      = ringing_r;
    assign bus.mode         = state_r;
    assign bus.disp_sel     = disp_sel_r;
endmodule
